bcd_conv_arbiter: RTL and testbench
===================================

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter BIN_N, default 16: binary operand width.
REQ-003 Parameter BCD_N, default 20: BCD result width.
REQ-004 Parameter TIMEOUT_CYC, default 64: watchdog limit in BUSY cycles.
REQ-005 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 req_i  input  N_REQ  per-requester request level; held high until granted.
REQ-008 bin_i  input  N_REQ*BIN_N  packed operands; requester k at [k*BIN_N +: BIN_N].
REQ-009 gnt_o  output  N_REQ  one-hot grant; one-cycle pulse on acceptance.
REQ-010 conv_start_o  output  1  one-cycle start pulse to the shared converter.
REQ-011 conv_bin_o  output  BIN_N  registered operand to the converter.
REQ-012 conv_ready_i  input  1  converter idle.
REQ-013 conv_done_i  input  1  converter result valid this cycle.
REQ-014 conv_bcd_i  input  BCD_N  converter result; sampled only with conv_done_i.
REQ-015 rsp_valid_o  output  1  response valid.
REQ-016 rsp_ready_i  input  1  response consumer ready.
REQ-017 rsp_id_o  output  $clog2(N_REQ)  index of the served requester.
REQ-018 rsp_bcd_o  output  BCD_N  captured BCD result.
REQ-019 rsp_err_o  output  1  watchdog-timeout flag.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, BUSY and RESP.
REQ-021 IDLE: when any req_i is high and conv_ready_i=1, assert gnt_o for the round-robin winner that cycle, latch its operand and index, then go to ISSUE; otherwise no grant.
REQ-022 Round-robin: search starts at pointer ptr and wraps modulo N_REQ; ptr SHALL become winner+1 (mod N_REQ) on each grant.
REQ-023 ISSUE: assert conv_start_o for exactly one cycle with conv_bin_o = latched operand, then go to BUSY.
REQ-024 BUSY: on conv_done_i, capture conv_bcd_i into rsp_bcd_o, clear rsp_err_o, then go to RESP.
REQ-025 RESP: hold rsp_valid_o=1 with rsp_id_o, rsp_bcd_o and rsp_err_o stable until rsp_ready_i=1; then return to IDLE.
REQ-026 Latency: grant to conv_start_o = 1 cycle; conv_done_i to rsp_valid_o = 1 cycle.
REQ-027 req_i SHALL be sampled only in IDLE; a new grant SHALL NOT occur in the cycle the response handshakes (no bypass).
REQ-028 conv_done_i outside BUSY SHALL be ignored.
REQ-029 conv_bin_o SHALL remain stable from ISSUE until the next grant.

Reset
REQ-030 On reset_i: state IDLE, ptr 0, and gnt_o, conv_start_o, conv_bin_o, rsp_valid_o, rsp_id_o, rsp_bcd_o and rsp_err_o all 0; any in-flight operation is discarded.

Configuration
REQ-031 With macro BCD_ARB_TIMEOUT_EN defined: a counter runs in BUSY, and reaching TIMEOUT_CYC cycles without conv_done_i enters RESP with rsp_err_o=1 and rsp_bcd_o=0.
REQ-032 With BCD_ARB_TIMEOUT_EN undefined: no counter exists, rsp_err_o is constant 0, and BUSY waits indefinitely.

Structure
REQ-033 Package bcd_arb_pkg SHALL hold the arb_state_t enum and default width constants.
REQ-034 Sub-module bcd_rr_picker SHALL be combinational and map (req, ptr) to one-hot grant, winner index and an any flag.

Verification
REQ-035 Single request: req_i=0001, slot0=1234 -> gnt_o=0001 for one cycle; conv_start_o one cycle later; rsp_bcd_o=20'h01234, rsp_id_o=0, rsp_err_o=0.
REQ-036 All four requesting continuously, operands 65535/0/9/100 -> grant order 0,1,2,3,0 with results 0x65535, 0x00000, 0x00009, 0x00100.
REQ-037 rsp_ready_i held low for 10 cycles -> rsp_valid_o and data stable throughout; no grant issued.
REQ-038 Converter stub never asserts done, TIMEOUT_CYC=8, macro defined -> rsp_err_o=1 and rsp_bcd_o=0 after 8 BUSY cycles; macro undefined -> still BUSY after 100 cycles.
REQ-039 reset_i pulsed while in BUSY -> all outputs 0 and state IDLE; afterwards, with only req_i[3] high, requester 3 is granted.
REQ-040 conv_ready_i low while req_i=0010 -> no gnt_o until conv_ready_i rises, then gnt_o=0010 in that same cycle.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared state encoding and default widths for the BCD converter arbiter.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_BIN_N       = 16;
  localparam int DEF_BCD_N       = 20;
  localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/bcd_rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module bcd_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned k;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % 32'(N_REQ);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among N_REQ requesters.
// Define BCD_ARB_TIMEOUT_EN to add a BUSY watchdog that returns an error response.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int BIN_N       = DEF_BIN_N,
  parameter int BCD_N       = DEF_BCD_N,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*BIN_N-1:0]   bin_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic                     conv_start_o,
  output logic [BIN_N-1:0]         conv_bin_o,
  input  logic                     conv_ready_i,
  input  logic                     conv_done_i,
  input  logic [BCD_N-1:0]         conv_bcd_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0] rsp_id_o,
  output logic [BCD_N-1:0]         rsp_bcd_o,
  output logic                     rsp_err_o
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("bcd_conv_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic             take;
  logic             timeout;

  bcd_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ptr_nxt = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Grant is combinational in IDLE so it appears in the cycle conv_ready_i rises.
  always_comb begin
    state_nxt    = state;
    gnt_o        = '0;
    conv_start_o = 1'b0;
    rsp_valid_o  = 1'b0;
    take         = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && conv_ready_i && !reset_i) begin
          gnt_o     = pick_gnt;
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        conv_start_o = 1'b1;
        state_nxt    = BUSY;
      end
      BUSY: begin
        if (conv_done_i || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr        <= '0;
      conv_bin_o <= '0;
      rsp_id_o   <= '0;
      rsp_bcd_o  <= '0;
    end else begin
      if (take) begin
        ptr        <= ptr_nxt;
        conv_bin_o <= bin_i[pick_idx*BIN_N +: BIN_N];
        rsp_id_o   <= pick_idx;
      end
      if (state == BUSY) begin
        if (conv_done_i)  rsp_bcd_o <= conv_bcd_i;
        else if (timeout) rsp_bcd_o <= '0;
      end
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Fires on the TIMEOUT_CYC-th BUSY cycle without conv_done_i.
  assign timeout = (state == BUSY) && !conv_done_i && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)             wd_cnt <= '0;
    else if (state != BUSY)  wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (state == BUSY) begin
      if (conv_done_i)  err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign rsp_err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with a behavioural converter stub.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  req_i = '0;
  logic [63:0] bin_i = '0;
  logic [3:0]  gnt_o;
  logic        conv_start_o;
  logic [15:0] conv_bin_o;
  logic        conv_ready_i = 1'b1;
  logic        conv_done_i = 1'b0;
  logic [19:0] conv_bcd_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [1:0]  rsp_id_o;
  logic [19:0] rsp_bcd_o;
  logic        rsp_err_o;

  int n_cmp = 0;
  int n_err = 0;

  logic        stub_dead = 1'b0;
  int          stub_cnt = 0;
  logic [15:0] stub_op = '0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .N_REQ       (4),
    .BIN_N       (16),
    .BCD_N       (20),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .bin_i        (bin_i),
    .gnt_o        (gnt_o),
    .conv_start_o (conv_start_o),
    .conv_bin_o   (conv_bin_o),
    .conv_ready_i (conv_ready_i),
    .conv_done_i  (conv_done_i),
    .conv_bcd_i   (conv_bcd_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_bcd_o    (rsp_bcd_o),
    .rsp_err_o    (rsp_err_o)
  );

  function automatic logic [19:0] to_bcd(input logic [15:0] b);
    int unsigned v;
    logic [19:0] r;
    v = 32'(b);
    r = '0;
    for (int unsigned d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Converter stub: done three cycles after start unless stub_dead.
  always @(negedge clk) begin
    conv_done_i = 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        conv_done_i = 1'b1;
        conv_bcd_i  = to_bcd(stub_op);
      end
    end
    if (conv_start_o) begin
      stub_op = conv_bin_o;
      if (!stub_dead) stub_cnt = 3;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   32'(gnt_o),        32'd0);
    check({tag, "_start"}, 32'(conv_start_o), 32'd0);
    check({tag, "_bin"},   32'(conv_bin_o),   32'd0);
    check({tag, "_valid"}, 32'(rsp_valid_o),  32'd0);
    check({tag, "_id"},    32'(rsp_id_o),     32'd0);
    check({tag, "_bcd"},   32'(rsp_bcd_o),    32'd0);
    check({tag, "_err"},   32'(rsp_err_o),    32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Called right after a negedge with requests already driven.
  task automatic serve(input string tag, input int id, input logic [15:0] op,
                       input logic [19:0] bcd, input int unsigned hold, input bit drop);
    int n;
    n = 0;
    #1;
    while (gnt_o == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_gnt"}, 32'(gnt_o), 32'd1 << id);
    @(negedge clk);
    if (drop) req_i = '0;
    #1;
    check({tag, "_pulse"}, 32'(gnt_o),        32'd0);
    check({tag, "_start"}, 32'(conv_start_o), 32'd1);
    check({tag, "_bin"},   32'(conv_bin_o),   32'(op));
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    check({tag, "_id"},    32'(rsp_id_o),    32'(id));
    check({tag, "_bcd"},   32'(rsp_bcd_o),   32'(bcd));
    check({tag, "_err"},   32'(rsp_err_o),   32'd0);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, "_hvalid"}, 32'(rsp_valid_o), 32'd1);
      check({tag, "_hbcd"},   32'(rsp_bcd_o),   32'(bcd));
      check({tag, "_hid"},    32'(rsp_id_o),    32'(id));
      check({tag, "_hgnt"},   32'(gnt_o),       32'd0);
    end
    @(negedge clk);
    rsp_ready_i = 1'b1;
    #1;
    check({tag, "_nobypass"}, 32'(gnt_o), 32'd0);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    #1;
    check({tag, "_released"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    reset_i = 1'b0;

    // Single requester
    @(negedge clk);
    bin_i[15:0] = 16'd1234;
    req_i = 4'b0001;
    serve("single", 0, 16'd1234, 20'h01234, 0, 1'b1);
    do_reset;

    // Four continuous requesters; first response back-pressured for 10 cycles
    @(negedge clk);
    bin_i = {16'd100, 16'd9, 16'd0, 16'd65535};
    req_i = 4'b1111;
    serve("rr0", 0, 16'd65535, 20'h65535, 10, 1'b0);
    serve("rr1", 1, 16'd0,     20'h00000, 0,  1'b0);
    serve("rr2", 2, 16'd9,     20'h00009, 0,  1'b0);
    serve("rr3", 3, 16'd100,   20'h00100, 0,  1'b0);
    serve("rr4", 0, 16'd65535, 20'h65535, 0,  1'b1);

    // Converter not ready holds off the grant
    @(negedge clk);
    conv_ready_i = 1'b0;
    req_i = 4'b0010;
    bin_i[31:16] = 16'd42;
    for (int unsigned h = 0; h < 5; h++) begin
      #1;
      check("nordy_gnt", 32'(gnt_o), 32'd0);
      @(negedge clk);
    end
    conv_ready_i = 1'b1;
    #1;
    check("rdy_same_cycle", 32'(gnt_o), 32'b0010);
    serve("rdy", 1, 16'd42, 20'h00042, 0, 1'b1);

    // Converter never completes
    stub_dead = 1'b1;
    @(negedge clk);
    bin_i[15:0] = 16'd777;
    req_i = 4'b0001;
    #1;
    check("to_gnt", 32'(gnt_o), 32'b0001);
    @(negedge clk);
    req_i = '0;
    #1;
    check("to_start", 32'(conv_start_o), 32'd1);
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      @(negedge clk); #1; n++;
    end
`ifdef BCD_ARB_TIMEOUT_EN
    check("to_cycles", 32'(n),           32'd9);
    check("to_err",    32'(rsp_err_o),   32'd1);
    check("to_bcd",    32'(rsp_bcd_o),   32'd0);
    check("to_valid",  32'(rsp_valid_o), 32'd1);
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
`else
    check("to_wait",   32'(n),           32'd100);
    check("to_valid",  32'(rsp_valid_o), 32'd0);
    check("to_err",    32'(rsp_err_o),   32'd0);
    do_reset;
`endif

    // Reset pulsed while BUSY, then requester 3 alone
    @(negedge clk);
    req_i = 4'b0001;
    #1;
    check("rb_gnt", 32'(gnt_o), 32'b0001);
    @(negedge clk);
    req_i = '0;
    #1;
    check("rb_start", 32'(conv_start_o), 32'd1);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    #1;
    check_idle("rb_reset");
    @(negedge clk);
    reset_i = 1'b0;
    stub_dead = 1'b0;
    bin_i[63:48] = 16'd9999;
    req_i = 4'b1000;
    serve("after_rst", 3, 16'd9999, 20'h09999, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no completion expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
